// File: rtl/mul_sequencer.sv
// mul_sequencer: drives operands and clear to a fixed-latency multiplier and captures its 64-bit product.
module mul_sequencer #(
  parameter int LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a_in,
  input  logic [31:0] op_b_in,
  input  logic [63:0] product_in,
  output logic [31:0] multiplicand_out,
  output logic [31:0] multiplier_out,
  output logic        mul_clear_n,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
  state_t state;
  logic [7:0] cnt;
  // Outputs are registered from the next state, so each one lines up with the state it describes.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mul_clear_n <= 1'b0;
      multiplicand_out <= '0;
      multiplier_out <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      mul_clear_n <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          multiplicand_out <= op_a_in;
          multiplier_out <= op_b_in;
          mul_clear_n <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: begin
          state <= RUN;
          cnt <= CNT_INIT;
        end
        RUN: if (cnt == 8'd0) state <= CAPTURE;
             else cnt <= cnt - 8'd1;
        CAPTURE: begin
          state <= DONE;
          hi_out <= product_in[63:32];
          lo_out <= product_in[31:0];
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for two sequencers (LATENCY 32 and 1) driving a latency-accurate multiplier model.
module tb_mul_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rstn[2], start[2], clr[2], busy[2], done[2];
  logic [31:0] a_in[2], b_in[2], mcand[2], mplier[2], hi[2], lo[2];
  logic [63:0] prod[2];
  int n_vec = 0, n_err = 0;
  int dones[2] = '{0, 0};
  typedef struct {logic [31:0] hi, lo; int at;} exp_t;
  exp_t q0[$], q1[$];

  mul_sequencer #(.LATENCY(32)) u32 (
    .clk(clk), .reset(rstn[0]), .start(start[0]), .op_a_in(a_in[0]), .op_b_in(b_in[0]),
    .product_in(prod[0]), .multiplicand_out(mcand[0]), .multiplier_out(mplier[0]),
    .mul_clear_n(clr[0]), .busy(busy[0]), .done(done[0]), .hi_out(hi[0]), .lo_out(lo[0]));
  mul_sequencer #(.LATENCY(1)) u1 (
    .clk(clk), .reset(rstn[1]), .start(start[1]), .op_a_in(a_in[1]), .op_b_in(b_in[1]),
    .product_in(prod[1]), .multiplicand_out(mcand[1]), .multiplier_out(mplier[1]),
    .mul_clear_n(clr[1]), .busy(busy[1]), .done(done[1]), .hi_out(hi[1]), .lo_out(lo[1]));

  function automatic int lat(int i);
    return i != 0 ? 1 : 32;
  endfunction

  // Multiplier model: product is garbage until LATENCY edges after clear is released.
  for (genvar g = 0; g < 2; g++) begin : mm
    int c = 0;
    logic signed [63:0] p;
    assign p = $signed(mcand[g]) * $signed(mplier[g]);
    always @(posedge clk) c <= !clr[g] ? 0 : (c < 255 ? c + 1 : c);
    assign prod[g] = c >= lat(g) ? p : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++)
      if (done[i]) begin
        dones[i]++;
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected done on dut %0d at cycle %0d", i, cyc);
        end else begin
          e = i == 0 ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d hi_out", i), 64'(hi[i]), 64'(e.hi));
          chk($sformatf("dut%0d lo_out", i), 64'(lo[i]), 64'(e.lo));
          chk($sformatf("dut%0d done cycle", i), 64'(cyc), 64'(e.at));
        end
      end
  end

  task automatic push(int i, logic [31:0] eh, logic [31:0] el, int at);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.at = at;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el);
    @(negedge clk);
    a_in[i] = a;
    b_in[i] = b;
    start[i] = 1'b1;
    push(i, eh, el, cyc + 1 + lat(i) + 2);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while (busy[i] && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("reached idle", 64'(busy[i]), 64'(0));
  endtask

  task automatic run_op(int i, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el);
    int nb = 0, nc = 0;
    issue(i, a, b, eh, el);
    a_in[i] = ~a;
    b_in[i] = ~b;
    while (busy[i] && nb < 400) begin
      nb++;
      if (!clr[i]) nc++;
      @(negedge clk);
    end
    chk("busy cycles", 64'(nb), 64'(lat(i) + 3));
    chk("clear low cycles", 64'(nc), 64'(1));
    chk("operand a hold", 64'(mcand[i]), 64'(a));
    chk("operand b hold", 64'(mplier[i]), 64'(b));
    repeat (3) @(negedge clk);
    chk("hi/lo hold", {hi[i], lo[i]}, {eh, el});
  endtask

  initial begin
    int e0, d0, n;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b1;
      start[i] = 1'b0;
      a_in[i] = '0;
      b_in[i] = '0;
    end
    #2;
    rstn[0] = 1'b0;
    rstn[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset busy/done/clear_n", 64'({busy[i], done[i], clr[i]}), 64'(0));
      chk("reset operands", {mcand[i], mplier[i]}, 64'(0));
      chk("reset hi/lo", {hi[i], lo[i]}, 64'(0));
    end
    @(negedge clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("post-reset clear_n/busy", 64'({clr[i], busy[i]}), 64'(2'b10));
    run_op(0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(0, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_op(1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000);
    // Start held high: second op must begin at E36 with the new operand.
    d0 = dones[0];
    @(negedge clk);
    a_in[0] = 32'd11;
    b_in[0] = 32'd2;
    start[0] = 1'b1;
    e0 = cyc + 1;
    push(0, 32'd0, 32'd22, e0 + 34);
    push(0, 32'd0, 32'd10, e0 + 36 + 34);
    repeat (10) @(negedge clk);
    a_in[0] = 32'd5;
    @(negedge clk);
    chk("b2b operand held in RUN", 64'(mcand[0]), 64'(11));
    while (cyc < e0 + 36) @(negedge clk);
    start[0] = 1'b0;
    chk("b2b second operand", 64'(mcand[0]), 64'(5));
    wait_idle(0);
    chk("b2b done pulses", 64'(dones[0] - d0), 64'(2));
    // Start pulsed during DONE is ignored.
    issue(0, 32'd3, 32'd4, 32'd0, 32'd12);
    n = 0;
    while (!done[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("done reached", 64'(done[0]), 64'(1));
    start[0] = 1'b1;
    a_in[0] = 32'd9;
    @(negedge clk);
    start[0] = 1'b0;
    chk("start in DONE: busy", 64'(busy[0]), 64'(0));
    chk("start in DONE: clear_n", 64'(clr[0]), 64'(1));
    @(negedge clk);
    chk("start in DONE: still idle", 64'(busy[0]), 64'(0));
    chk("start in DONE: operand", 64'(mcand[0]), 64'(3));
    // Reset mid-RUN with cnt at 10 (22 edges after acceptance).
    issue(0, 32'd100, 32'd200, 32'd0, 32'd20000);
    e0 = cyc;
    while (cyc < e0 + 22) @(negedge clk);
    chk("busy before abort", 64'(busy[0]), 64'(1));
    rstn[0] = 1'b0;
    q0.delete();
    #1;
    chk("abort busy/done/clear_n", 64'({busy[0], done[0], clr[0]}), 64'(0));
    chk("abort operands", {mcand[0], mplier[0]}, 64'(0));
    chk("abort hi/lo", {hi[0], lo[0]}, 64'(0));
    @(negedge clk);
    rstn[0] = 1'b1;
    d0 = dones[0];
    repeat (40) @(negedge clk);
    chk("after abort busy", 64'(busy[0]), 64'(0));
    chk("after abort no done", 64'(dones[0] - d0), 64'(0));
    chk("after abort hi/lo", {hi[0], lo[0]}, 64'(0));
    chk("after abort clear_n", 64'(clr[0]), 64'(1));
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
